// File: rtl/sample_playback_evaluator.sv
// sample_playback_evaluator
// Plays stored input bytes back to the circuit under evaluation one sample at a
// time. It captures each response and accumulates the masked count of mismatched
// bits, which is the raw fitness error. The accumulator saturates at its maximum.
// Optional feature macro: SAMPLE_TIMEOUT_EN. When it is defined, a sample that
// gets no response within TIMEOUT_CYCLES is scored as fully mismatched.
module sample_playback_evaluator #(
    parameter int NUM_SAMPLES    = 3,
    parameter int ERR_W          = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                         iClock,
    input  logic                         iResetN,
    input  logic                         iStart,
    input  logic                         iAbort,
    input  logic [(NUM_SAMPLES+1)*8-1:0] iInputSequences,
    input  logic [(NUM_SAMPLES+1)*8-1:0] iExpectedOutputs,
    input  logic [(NUM_SAMPLES+1)*8-1:0] iValidOutputs,
    output logic [7:0]                   oCircuitInput,
    output logic                         oCircuitInputValid,
    input  logic [7:0]                   iCircuitOutput,
    input  logic                         iCircuitOutputValid,
    output logic [31:0]                  oSampleIndex,
    output logic                         oBusy,
    output logic                         oDone,
    output logic [ERR_W-1:0]             oErrorCount
);

    localparam int NUM_ENTRIES = NUM_SAMPLES + 1;
    localparam int IDX_W       = (NUM_SAMPLES > 0) ? $clog2(NUM_ENTRIES) : 1;
    localparam int SUM_W       = ERR_W + 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SAMPLES);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_WAIT_RESP,
        ST_COMPARE,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [7:0]       resp_q, resp_d;
    logic [7:0]       circuit_input_q, circuit_input_d;

`ifdef SAMPLE_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] timer_q, timer_d;
`endif

    function automatic logic [7:0] sel_byte(input logic [NUM_ENTRIES*8-1:0] vec,
                                            input logic [IDX_W-1:0] i);
        return vec[i*8 +: 8];
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] b);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + 4'(b[i]);
        end
        return cnt;
    endfunction

    logic [7:0]       exp_byte;
    logic [7:0]       mask_byte;
    logic [7:0]       mismatch;
    logic [SUM_W-1:0] sum;
    logic [ERR_W-1:0] err_sat;
    logic [IDX_W-1:0] next_idx;

    // Score the captured response of the current sample and saturate the running total
    always_comb begin
        exp_byte  = sel_byte(iExpectedOutputs, idx_q);
        mask_byte = sel_byte(iValidOutputs, idx_q);
        mismatch  = (resp_q ^ exp_byte) & mask_byte;
        sum       = SUM_W'(err_q) + SUM_W'(popcount8(mismatch));
        err_sat   = (sum > SUM_W'(ERR_MAX)) ? ERR_MAX : sum[ERR_W-1:0];
        next_idx  = idx_q + IDX_W'(1);
    end

    // Next-state and datapath updates for the playback sequencer
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        err_d           = err_q;
        resp_d          = resp_q;
        circuit_input_d = circuit_input_q;
`ifdef SAMPLE_TIMEOUT_EN
        timer_d         = timer_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    err_d           = '0;
                    idx_d           = '0;
                    circuit_input_d = sel_byte(iInputSequences, '0);
                    state_d         = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
`ifdef SAMPLE_TIMEOUT_EN
                timer_d = '0;
`endif
                if (iAbort) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_RESP;
                end
            end
            ST_WAIT_RESP: begin
                if (iAbort) begin
                    state_d = ST_IDLE;
                end else if (iCircuitOutputValid) begin
                    resp_d  = iCircuitOutput;
                    state_d = ST_COMPARE;
                end
`ifdef SAMPLE_TIMEOUT_EN
                else if (timer_q == TMO_LAST) begin
                    resp_d  = ~exp_byte;
                    state_d = ST_COMPARE;
                end else begin
                    timer_d = timer_q + TMO_W'(1);
                end
`endif
            end
            ST_COMPARE: begin
                if (iAbort) begin
                    state_d = ST_IDLE;
                end else begin
                    err_d = err_sat;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d           = next_idx;
                        circuit_input_d = sel_byte(iInputSequences, next_idx);
                        state_d         = ST_DRIVE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by reset
    always_ff @(posedge iClock or negedge iResetN) begin
        if (!iResetN) begin
            state_q         <= ST_IDLE;
            idx_q           <= '0;
            err_q           <= '0;
            resp_q          <= '0;
            circuit_input_q <= '0;
`ifdef SAMPLE_TIMEOUT_EN
            timer_q         <= '0;
`endif
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            err_q           <= err_d;
            resp_q          <= resp_d;
            circuit_input_q <= circuit_input_d;
`ifdef SAMPLE_TIMEOUT_EN
            timer_q         <= timer_d;
`endif
        end
    end

    assign oCircuitInput      = circuit_input_q;
    assign oCircuitInputValid = (state_q == ST_DRIVE);
    assign oSampleIndex       = 32'(idx_q);
    assign oBusy              = (state_q == ST_DRIVE) || (state_q == ST_WAIT_RESP) ||
                                (state_q == ST_COMPARE);
    assign oDone              = (state_q == ST_DONE);
    assign oErrorCount        = err_q;

endmodule

// File: tb/tb_sample_playback_evaluator.sv
// Testbench for sample_playback_evaluator: directed and randomized passes
// scored against a reference error model computed from the stored arrays.
module tb_sample_playback_evaluator;

    localparam int NS      = 3;
    localparam int NE      = NS + 1;
    localparam int EW      = 5;
    localparam int TC      = 4;
    localparam int ERR_MAX = (1 << EW) - 1;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [NE*8-1:0]   in_vec;
    logic [NE*8-1:0]   exp_vec;
    logic [NE*8-1:0]   mask_vec;
    logic [7:0]        circuit_input;
    logic              circuit_input_valid;
    logic [7:0]        circuit_output;
    logic              circuit_output_valid;
    logic [31:0]       sample_index;
    logic              busy;
    logic              done;
    logic [EW-1:0]     error_count;

    logic [7:0] in_seq   [NE];
    logic [7:0] exp_out  [NE];
    logic [7:0] mask_tab [NE];
    logic [7:0] resp_tab [NE];

    int test_count = 0;
    int fail_count = 0;

    sample_playback_evaluator #(
        .NUM_SAMPLES   (NS),
        .ERR_W         (EW),
        .TIMEOUT_CYCLES(TC)
    ) dut (
        .iClock             (clk),
        .iResetN            (rst_n),
        .iStart             (start),
        .iAbort             (abort),
        .iInputSequences    (in_vec),
        .iExpectedOutputs   (exp_vec),
        .iValidOutputs      (mask_vec),
        .oCircuitInput      (circuit_input),
        .oCircuitInputValid (circuit_input_valid),
        .iCircuitOutput     (circuit_output),
        .iCircuitOutputValid(circuit_output_valid),
        .oSampleIndex       (sample_index),
        .oBusy              (busy),
        .oDone              (done),
        .oErrorCount        (error_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        test_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic load_arrays();
        for (int i = 0; i < NE; i++) begin
            in_vec[i*8 +: 8]   = in_seq[i];
            exp_vec[i*8 +: 8]  = exp_out[i];
            mask_vec[i*8 +: 8] = mask_tab[i];
        end
    endtask

    // Error total of the first n samples, saturated at the accumulator maximum
    function automatic int model_error(input int n);
        int total = 0;
        for (int i = 0; i < n; i++) begin
            total += $countones((resp_tab[i] ^ exp_out[i]) & mask_tab[i]);
        end
        return (total > ERR_MAX) ? ERR_MAX : total;
    endfunction

    // One pass: response latency 1..max_lat, optional abort while waiting on
    // sample abort_at (-1 for none), optional stray iStart mid-pass
    task automatic applyStimulus(input int max_lat, input int abort_at, input bit poke_start);
        int idx = 0;
        int cnt = 0;
        int cycles = 0;
        bit waiting = 0;
        bit finished = 0;
        bit aborted = 0;
        load_arrays();
        @(negedge clk);
        start = 1'b1;
        while (!finished && cycles < 300) begin
            @(negedge clk);
            cycles++;
            start                = 1'b0;
            abort                = 1'b0;
            circuit_output_valid = 1'b0;
            circuit_output       = 8'($urandom);
            if (poke_start && cycles == 4) start = 1'b1;
            if (aborted) begin
                checkOutput("abortBusy", 32'(busy), 32'd0);
                checkOutput("abortDone", 32'(done), 32'd0);
                checkOutput("abortErr", 32'(error_count), 32'(model_error(abort_at)));
                finished = 1;
            end else if (done) begin
                checkOutput("passErr", 32'(error_count), 32'(model_error(NE)));
                checkOutput("passSamples", 32'(idx), 32'(NE));
                checkOutput("doneBusy", 32'(busy), 32'd0);
                if (max_lat == 1) checkOutput("passLen", 32'(cycles), 32'(3*NE+1));
                finished = 1;
            end else if (waiting) begin
                checkOutput("waitBusy", 32'(busy), 32'd1);
                cnt--;
                if (cnt == 0) begin
                    waiting              = 0;
                    circuit_output_valid = 1'b1;
                    circuit_output       = resp_tab[idx];
                    if (idx == abort_at) begin
                        abort   = 1'b1;
                        aborted = 1;
                    end else begin
                        idx++;
                    end
                end
            end else if (circuit_input_valid) begin
                checkOutput("drvByte", 32'(circuit_input), 32'(in_seq[idx]));
                checkOutput("drvIdx", sample_index, 32'(idx));
                if (idx == 0) checkOutput("startClearsErr", 32'(error_count), 32'd0);
                cnt     = $urandom_range(max_lat, 1);
                waiting = 1;
            end
        end
        if (!finished) checkOutput("passTimeout", 32'd0, 32'd1);
        @(negedge clk);
        start                = 1'b0;
        abort                = 1'b0;
        circuit_output_valid = 1'b0;
        checkOutput("afterDoneLow", 32'(done), 32'd0);
        checkOutput("afterIdle", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n                = 1'b0;
        start                = 1'b0;
        abort                = 1'b0;
        circuit_output       = '0;
        circuit_output_valid = 1'b0;
        in_vec               = '0;
        exp_vec              = '0;
        mask_vec             = '0;
        repeat (2) @(negedge clk);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);
        checkOutput("rstErr", 32'(error_count), 32'd0);
        checkOutput("rstValid", 32'(circuit_input_valid), 32'd0);
        checkOutput("rstIdx", sample_index, 32'd0);
        checkOutput("rstInput", 32'(circuit_input), 32'd0);
        rst_n = 1'b1;

        // Exact match with minimum latency
        for (int i = 0; i < NE; i++) begin
            in_seq[i]   = 8'(8'h11 * (i + 1));
            exp_out[i]  = 8'($urandom);
            mask_tab[i] = 8'hFF;
            resp_tab[i] = exp_out[i];
        end
        applyStimulus(1, -1, 0);

        // Masked mismatches: +4 on sample 2, masked-off garbage on sample 1
        exp_out[2] = 8'hF0; mask_tab[2] = 8'h3C; resp_tab[2] = 8'h0F;
        mask_tab[1] = 8'h00; resp_tab[1] = 8'hFF;
        applyStimulus(2, -1, 0);

        // Abort while waiting on sample 2, then a fresh pass
        resp_tab[0] = ~exp_out[0];
        applyStimulus(1, 2, 0);
        applyStimulus(1, -1, 0);

        // Saturation with a stray start mid-pass
        for (int i = 0; i < NE; i++) begin
            exp_out[i] = 8'h00; mask_tab[i] = 8'hFF; resp_tab[i] = 8'hFF;
        end
        applyStimulus(1, -1, 1);

        // Abort in IDLE leaves the held error untouched
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        checkOutput("idleAbortErr", 32'(error_count), 32'(ERR_MAX));
        checkOutput("idleAbortBusy", 32'(busy), 32'd0);

        // Reset while in COMPARE of sample 0
        in_seq[0] = 8'hA5;
        load_arrays();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); circuit_output_valid = 1'b1; circuit_output = 8'hFF;
        @(negedge clk); circuit_output_valid = 1'b0;
        checkOutput("preRstBusy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstErr", 32'(error_count), 32'd0);
        checkOutput("midRstInput", 32'(circuit_input), 32'd0);
        checkOutput("midRstIdx", sample_index, 32'd0);
        checkOutput("midRstDone", 32'(done), 32'd0);
        circuit_output_valid = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("lateRespBusy", 32'(busy), 32'd0);
        checkOutput("lateRespValid", 32'(circuit_input_valid), 32'd0);
        checkOutput("lateRespErr", 32'(error_count), 32'd0);
        circuit_output_valid = 1'b0;

        // Randomized passes
        for (int p = 0; p < 8; p++) begin
            int ab;
            for (int i = 0; i < NE; i++) begin
                in_seq[i]   = 8'($urandom);
                exp_out[i]  = 8'($urandom);
                case ($urandom_range(3, 0))
                    0:       mask_tab[i] = 8'h00;
                    1:       mask_tab[i] = 8'hFF;
                    default: mask_tab[i] = 8'($urandom);
                endcase
                resp_tab[i] = ($urandom_range(1, 0) == 0) ? exp_out[i] : 8'($urandom);
            end
            ab = ($urandom_range(3, 0) == 0) ? int'($urandom_range(NS, 0)) : -1;
            applyStimulus(int'($urandom_range(TC, 1)), ab, p[0]);
        end

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
